ysyx_22040125_hazard_ctrl: RTL and testbench
============================================

Name: ysyx_22040125_hazard_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage RV64 core. It sits beside the forwarding unit and covers the hazards that forwarding cannot resolve: load-use, load-to-ID-branch, multi-cycle MDU ops and data-memory wait states. It also issues the ID-stage redirect flush. It drives stall/flush controls to the PC and to the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and tracks MDU occupancy with a small FSM plus a watchdog.

Parameters:
- MDU_TIMEOUT, 64: max cycles in S_MDU before forced release; must be ≥2.
- CNT_W, 7: width of the MDU watchdog counter; must satisfy 2^CNT_W > MDU_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_rs1  in  5  ID source reg 1 (also branch/JALR rs1)
- id_rs2  in  5  ID source reg 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_is_branch  in  1  ID instruction compares or adds regs in ID (branch/JALR)
- id_redirect  in  1  ID resolved taken branch or jump
- exe_rd  in  5  EXE destination
- exe_reg_wen  in  1  EXE writes a register
- exe_is_load  in  1  EXE instruction is a load
- exe_mdu_start  in  1  1-cycle pulse: MDU op entered EXE
- mdu_done  in  1  1-cycle pulse: MDU result valid
- mem_rd  in  5  MEM destination
- mem_reg_wen  in  1  MEM writes a register
- mem_is_load  in  1  MEM instruction is a load
- mem_req_valid  in  1  data-memory request outstanding
- mem_ready  in  1  data memory accepts/completes this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  bubble IF/ID
- id_exe_stall  out  1  hold ID/EX
- id_exe_flush  out  1  bubble ID/EX
- exe_mem_stall  out  1  hold EX/MEM
- exe_mem_flush  out  1  bubble EX/MEM
- mem_wb_flush  out  1  bubble MEM/WB
- mdu_timeout  out  1  sticky watchdog error

Behaviour:
- Reset is synchronous and active-high: state=S_RUN, watchdog=0, mdu_timeout=0. While rst=1, all four flushes are 1 and all stalls are 0.
- All stall/flush outputs are combinational from state and inputs (0-cycle latency). A register with stall=1 and flush=1 simultaneously resolves to flush.
- A match requires the destination ≠ x0 and its wen=1.
- Hazard terms:
  - freeze = mem_req_valid & ~mem_ready
  - mdu_stall = (S_RUN & exe_mdu_start) | (S_MDU & ~mdu_done)
  - lu = exe_is_load & exe match on (id_use_rs1 & rs1) or (id_use_rs2 & rs2)
  - bl = id_is_branch & mem_is_load & mem match on rs1/rs2 with the same use qualifiers
  - dh = lu | bl
- Priority, highest first:
  1. freeze: pc, if_id, id_exe and exe_mem stalls = 1; mem_wb_flush = 1.
  2. mdu_stall: pc, if_id and id_exe stalls = 1; exe_mem_flush = 1.
  3. dh: pc and if_id stalls = 1; id_exe_flush = 1.
  4. id_redirect: if_id_flush = 1.
  5. Otherwise: all outputs 0.
- id_redirect is ignored whenever any higher-priority condition holds.
- Result: load-use costs 1 bubble. A branch depending on a load costs 2 bubbles (lu, then bl).
- FSM:
  - S_RUN → S_MDU on exe_mdu_start & ~freeze.
  - S_MDU → S_RUN on mdu_done, including during freeze; the MDU holds its result.
  - S_MDU → S_RUN on watchdog == MDU_TIMEOUT-1. This also sets mdu_timeout, which is cleared only by rst.
  - Watchdog: cleared on S_MDU entry, increments each S_MDU cycle, saturates.
  - exe_mdu_start in S_MDU is illegal and ignored.
  - mdu_done in S_RUN is ignored.
- Reset mid-S_MDU returns to S_RUN next edge and drops all stalls.

Optional Feature:
HAZARD_PERF_CNT_EN: adds output ports stall_cycles[63:0], load_use_cnt[63:0] and redirect_cnt[63:0], each reset to 0.
- stall_cycles increments every cycle pc_stall=1.
- load_use_cnt increments every cycle dh is the winning condition.
- redirect_cnt increments on each honoured if_id_flush from id_redirect.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load x5 in EXE, ID add reads x5 → pc_stall=if_id_stall=id_exe_flush=1 for exactly 1 cycle; same case with exe_rd=x0 → no stall.
- Load x7 in EXE, ID beq on x7 → 2 stall cycles (lu, then bl with mem_rd=7), then 0.
- exe_mdu_start, mdu_done 10 cycles later → 10 stall cycles with exe_mem_flush=1, S_RUN on cycle 11; the done cycle itself has no stall.
- MDU with no done, MDU_TIMEOUT=64 → release after 64 cycles; mdu_timeout=1 and stays 1 until rst.
- mem_req_valid=1, mem_ready=0 for 3 cycles, with concurrent lu and id_redirect → freeze outputs only for 3 cycles; redirect not honoured during freeze; lu resolves afterwards.
- rst asserted mid-S_MDU → next cycle all stalls 0, all flushes 1 while rst=1, mdu_timeout=0.

Source files
------------

// File: rtl/ysyx_22040125_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22040125_hazard_ctrl
//
// Purpose:
//   Stall/flush controller for the 5-stage RV64 pipeline. It covers the hazards
//   that the forwarding unit cannot resolve:
//   - data-memory wait states (freeze)
//   - multi-cycle MDU operations
//   - load-use in EXE
//   - a load in MEM feeding a branch or JALR that resolves in ID
//   It also issues the IF/ID flush for an ID-stage redirect. A two-state FSM
//   tracks MDU occupancy. A watchdog forces a release if the MDU never signals
//   done, and then raises a sticky error.
//
// Parameters:
//   MDU_TIMEOUT  cycles allowed in S_MDU before a forced release (>= 2)
//   CNT_W        watchdog width, 2**CNT_W > MDU_TIMEOUT
//
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   id_rs1/id_rs2                 ID source registers
//   id_use_rs1/id_use_rs2         ID instruction really reads that source
//   id_is_branch                  ID instruction consumes registers in ID
//   id_redirect                   ID resolved a taken branch or jump
//   exe_rd/exe_reg_wen            EXE destination and its write enable
//   exe_is_load                   EXE holds a load
//   exe_mdu_start                 pulse: an MDU op entered EXE
//   mdu_done                      pulse: MDU result valid
//   mem_rd/mem_reg_wen            MEM destination and its write enable
//   mem_is_load                   MEM holds a load
//   mem_req_valid/mem_ready       data-memory handshake
//   pc_stall                      hold PC
//   if_id_stall/if_id_flush       IF/ID register control
//   id_exe_stall/id_exe_flush     ID/EX register control
//   exe_mem_stall/exe_mem_flush   EX/MEM register control
//   mem_wb_flush                  MEM/WB register control
//   mdu_timeout                   sticky watchdog error, cleared only by rst
//
// Optional build macro:
//   HAZARD_PERF_CNT_EN  adds the stall_cycles, load_use_cnt and redirect_cnt
//                       64-bit performance counters as extra output ports.
//
// A stage register that sees stall=1 and flush=1 together must take the
// flush. All stall/flush outputs are combinational (zero-cycle latency).
// ----------------------------------------------------------------------------
module ysyx_22040125_hazard_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       id_is_branch,
  input  logic       id_redirect,
  input  logic [4:0] exe_rd,
  input  logic       exe_reg_wen,
  input  logic       exe_is_load,
  input  logic       exe_mdu_start,
  input  logic       mdu_done,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_wen,
  input  logic       mem_is_load,
  input  logic       mem_req_valid,
  input  logic       mem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_exe_stall,
  output logic       id_exe_flush,
  output logic       exe_mem_stall,
  output logic       exe_mem_flush,
  output logic       mem_wb_flush,
  output logic       mdu_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [63:0] stall_cycles,
  output logic [63:0] load_use_cnt,
  output logic [63:0] redirect_cnt
`endif
);

  // Elaboration-time parameter sanity.
  if (MDU_TIMEOUT < 2) begin : g_bad_timeout
    $error("MDU_TIMEOUT must be at least 2");
  end
  if ((64'd1 << CNT_W) <= 64'(MDU_TIMEOUT)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for MDU_TIMEOUT");
  end

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MDU_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WD_MAX  = {CNT_W{1'b1}};

  typedef enum logic {
    S_RUN = 1'b0,
    S_MDU = 1'b1
  } state_t;

  // This is the winning hazard class after priority resolution.
  typedef enum logic [2:0] {
    W_NONE   = 3'd0,
    W_REDIR  = 3'd1,
    W_DH     = 3'd2,
    W_MDU    = 3'd3,
    W_FREEZE = 3'd4
  } win_t;

  state_t           state;
  logic [CNT_W-1:0] watchdog;

  logic freeze;
  logic mdu_stall;
  logic lu;
  logic bl;
  logic dh;
  win_t win;

  // A producer matches a consumer source only when the producer writes a
  // register other than x0 and the consumer really reads that source.
  function automatic logic src_hit(input logic [4:0] rd,
                                   input logic       wen,
                                   input logic [4:0] rs,
                                   input logic       use_rs);
    return use_rs && wen && (rd != 5'd0) && (rd == rs);
  endfunction

  // Hazard detection from FSM state and stage inputs.
  always_comb begin
    freeze    = mem_req_valid && !mem_ready;
    mdu_stall = ((state == S_RUN) && exe_mdu_start) ||
                ((state == S_MDU) && !mdu_done);
    lu        = exe_is_load &&
                (src_hit(exe_rd, exe_reg_wen, id_rs1, id_use_rs1) ||
                 src_hit(exe_rd, exe_reg_wen, id_rs2, id_use_rs2));
    // The branch compares in ID, so a load still in MEM cannot be forwarded
    // in time. This gives the second bubble of a load-to-branch dependency.
    bl        = id_is_branch && mem_is_load &&
                (src_hit(mem_rd, mem_reg_wen, id_rs1, id_use_rs1) ||
                 src_hit(mem_rd, mem_reg_wen, id_rs2, id_use_rs2));
    dh        = lu || bl;

    win = W_NONE;
    if (freeze)           win = W_FREEZE;
    else if (mdu_stall)   win = W_MDU;
    else if (dh)          win = W_DH;
    else if (id_redirect) win = W_REDIR;
  end

  // Stall/flush decode of the winning condition.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_stall  = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_stall = 1'b0;
    exe_mem_flush = 1'b0;
    mem_wb_flush  = 1'b0;
    if (rst) begin
      // Bubble every stage register and never hold during reset.
      if_id_flush   = 1'b1;
      id_exe_flush  = 1'b1;
      exe_mem_flush = 1'b1;
      mem_wb_flush  = 1'b1;
    end else begin
      case (win)
        W_FREEZE: begin
          // Freeze the whole front of the pipe. The instruction retiring from
          // MEM must not write back twice, so MEM/WB gets a bubble.
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_exe_stall  = 1'b1;
          exe_mem_stall = 1'b1;
          mem_wb_flush  = 1'b1;
        end
        W_MDU: begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_exe_stall  = 1'b1;
          exe_mem_flush = 1'b1;
        end
        W_DH: begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_exe_flush  = 1'b1;
        end
        W_REDIR: begin
          if_id_flush   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // MDU occupancy FSM and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      watchdog    <= '0;
      mdu_timeout <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          // The start is not taken during a freeze because EXE is being held.
          // An mdu_done pulse seen here is stray and is ignored.
          if (exe_mdu_start && !freeze) begin
            state    <= S_MDU;
            watchdog <= '0;
          end
        end
        S_MDU: begin
          // The watchdog keeps counting through freezes, and a done pulse is
          // honoured during a freeze because the MDU holds its result.
          if (watchdog != WD_MAX) begin
            watchdog <= watchdog + CNT_W'(1);
          end
          if (watchdog == WD_LAST) begin
            state       <= S_RUN;
            mdu_timeout <= 1'b1;
          end else if (mdu_done) begin
            state <= S_RUN;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      load_use_cnt <= '0;
      redirect_cnt <= '0;
    end else begin
      if (pc_stall) begin
        stall_cycles <= stall_cycles + 64'd1;
      end
      if (win == W_DH) begin
        load_use_cnt <= load_use_cnt + 64'd1;
      end
      if (win == W_REDIR) begin
        redirect_cnt <= redirect_cnt + 64'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22040125_hazard_ctrl.sv
// Bench for ysyx_22040125_hazard_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a cycle-count based reference model.
module tb_ysyx_22040125_hazard_ctrl;

  localparam int MDU_TIMEOUT = 64;
  localparam int CNT_W       = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, exe_rd, mem_rd;
  logic       id_use_rs1, id_use_rs2, id_is_branch, id_redirect;
  logic       exe_reg_wen, exe_is_load, exe_mdu_start, mdu_done;
  logic       mem_reg_wen, mem_is_load, mem_req_valid, mem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush;
  logic       exe_mem_stall, exe_mem_flush, mem_wb_flush, mdu_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [63:0] stall_cycles, load_use_cnt, redirect_cnt;
`endif

  ysyx_22040125_hazard_ctrl #(.MDU_TIMEOUT(MDU_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_is_branch(id_is_branch), .id_redirect(id_redirect),
    .exe_rd(exe_rd), .exe_reg_wen(exe_reg_wen), .exe_is_load(exe_is_load),
    .exe_mdu_start(exe_mdu_start), .mdu_done(mdu_done),
    .mem_rd(mem_rd), .mem_reg_wen(mem_reg_wen), .mem_is_load(mem_is_load),
    .mem_req_valid(mem_req_valid), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_exe_stall(id_exe_stall), .id_exe_flush(id_exe_flush),
    .exe_mem_stall(exe_mem_stall), .exe_mem_flush(exe_mem_flush),
    .mem_wb_flush(mem_wb_flush), .mdu_timeout(mdu_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .load_use_cnt(load_use_cnt),
    .redirect_cnt(redirect_cnt)
`endif
  );

  logic [8:0] dut_out;
  assign dut_out = {pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush,
                    exe_mem_stall, exe_mem_flush, mem_wb_flush, mdu_timeout};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: MDU busy flag, the cycle on which the MDU period
  // began, a free-running cycle count and the sticky error.
  bit m_in_mdu  = 1'b0;
  bit m_timeout = 1'b0;
  int m_cyc     = 0;
  int m_entry   = 0;
  longint unsigned m_stall_cnt = 0, m_lu_cnt = 0, m_redir_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic bit rd_hits(input logic [4:0] rd, input logic wen,
                                 input logic [4:0] rs, input logic use_rs);
    return use_rs && wen && (rd != 5'd0) && (rd == rs);
  endfunction

  // Winner: -1 reset, 0 none, 1 redirect, 2 data hazard, 3 MDU, 4 freeze.
  function automatic int model_win();
    bit lu_h, bl_h;
    if (rst) return -1;
    if (mem_req_valid && !mem_ready) return 4;
    if (m_in_mdu ? !mdu_done : exe_mdu_start) return 3;
    lu_h = exe_is_load && (rd_hits(exe_rd, exe_reg_wen, id_rs1, id_use_rs1) ||
                           rd_hits(exe_rd, exe_reg_wen, id_rs2, id_use_rs2));
    bl_h = id_is_branch && mem_is_load &&
           (rd_hits(mem_rd, mem_reg_wen, id_rs1, id_use_rs1) ||
            rd_hits(mem_rd, mem_reg_wen, id_rs2, id_use_rs2));
    if (lu_h || bl_h) return 2;
    if (id_redirect) return 1;
    return 0;
  endfunction

  // Bit order matches dut_out.
  function automatic logic [8:0] model_out(input int w);
    logic [8:0] o;
    o = '0;
    case (w)
      -1: begin o[6] = 1; o[4] = 1; o[2] = 1; o[1] = 1; end
       4: begin o[8] = 1; o[7] = 1; o[5] = 1; o[3] = 1; o[1] = 1; end
       3: begin o[8] = 1; o[7] = 1; o[5] = 1; o[2] = 1; end
       2: begin o[8] = 1; o[7] = 1; o[4] = 1; end
       1: o[6] = 1;
      default: ;
    endcase
    o[0] = m_timeout;
    return o;
  endfunction

  task automatic eval_cyc(input string tag);
    #1;
    check_val(tag, {55'd0, dut_out}, {55'd0, model_out(model_win())});
`ifdef HAZARD_PERF_CNT_EN
    check_val({tag, "_stall_cnt"}, stall_cycles, m_stall_cnt);
    check_val({tag, "_lu_cnt"}, load_use_cnt, m_lu_cnt);
    check_val({tag, "_redir_cnt"}, redirect_cnt, m_redir_cnt);
`endif
  endtask

  // Advance one clock. The model updates from the inputs held across the edge.
  task automatic tick();
    int w;
    int age;
    @(posedge clk);
    w = model_win();
    if (rst) begin
      m_stall_cnt = 0; m_lu_cnt = 0; m_redir_cnt = 0;
    end else begin
      if (w >= 2) m_stall_cnt++;
      if (w == 2) m_lu_cnt++;
      if (w == 1) m_redir_cnt++;
    end
    if (rst) begin
      m_in_mdu  = 1'b0;
      m_timeout = 1'b0;
    end else if (!m_in_mdu) begin
      if (exe_mdu_start && !(mem_req_valid && !mem_ready)) begin
        m_in_mdu = 1'b1;
        m_entry  = m_cyc + 1;
      end
    end else begin
      age = m_cyc - m_entry;
      if (age == MDU_TIMEOUT - 1) begin
        m_in_mdu  = 1'b0;
        m_timeout = 1'b1;
      end else if (mdu_done) begin
        m_in_mdu = 1'b0;
      end
    end
    m_cyc++;
    #1;
  endtask

  task automatic idle();
    rst = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_is_branch = 0; id_redirect = 0; exe_rd = 0; exe_reg_wen = 0;
    exe_is_load = 0; exe_mdu_start = 0; mdu_done = 0; mem_rd = 0;
    mem_reg_wen = 0; mem_is_load = 0; mem_req_valid = 0; mem_ready = 0;
  endtask

  int cnt;

  initial begin
    idle();
    rst = 1;
    #1;
    // Reset.
    for (int i = 0; i < 2; i++) begin
      eval_cyc("reset");
      check_val("rst_flushes", {if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush}, 4'b1111);
      tick();
    end
    idle();
    eval_cyc("post_reset");
    check_val("rst_timeout", mdu_timeout, 1'b0);
    tick();

    // Load x5 in EXE feeds an add in ID: exactly one bubble.
    exe_is_load = 1; exe_rd = 5; exe_reg_wen = 1; id_rs1 = 5; id_use_rs1 = 1;
    eval_cyc("lu_x5");
    check_val("lu_x5_ctrl", {pc_stall, if_id_stall, id_exe_flush}, 3'b111);
    tick();
    exe_is_load = 0; exe_rd = 0; exe_reg_wen = 0;
    mem_is_load = 1; mem_rd = 5; mem_reg_wen = 1;
    eval_cyc("lu_x5_after");
    check_val("lu_x5_after_stall", pc_stall, 1'b0);
    tick();
    idle();
    exe_is_load = 1; exe_rd = 0; exe_reg_wen = 1; id_rs1 = 0; id_use_rs1 = 1;
    eval_cyc("lu_x0");
    check_val("lu_x0_stall", pc_stall, 1'b0);
    tick();

    // Load x7 feeds a beq in ID: two bubbles, first lu then bl.
    idle();
    id_is_branch = 1; id_rs1 = 7; id_use_rs1 = 1; id_rs2 = 3; id_use_rs2 = 1;
    exe_is_load = 1; exe_rd = 7; exe_reg_wen = 1;
    cnt = 0;
    eval_cyc("bl_c1"); cnt += int'(pc_stall); tick();
    exe_is_load = 0; exe_rd = 0; exe_reg_wen = 0;
    mem_is_load = 1; mem_rd = 7; mem_reg_wen = 1;
    eval_cyc("bl_c2"); cnt += int'(pc_stall);
    check_val("bl_c2_flush", id_exe_flush, 1'b1);
    tick();
    mem_is_load = 0; mem_rd = 0; mem_reg_wen = 0;
    eval_cyc("bl_c3"); cnt += int'(pc_stall); tick();
    check_val("bl_bubbles", cnt, 2);

    // MDU op, done ten cycles after the start.
    idle();
    exe_mdu_start = 1;
    cnt = 0;
    eval_cyc("mdu_start"); cnt += int'(exe_mem_flush); tick();
    exe_mdu_start = 0;
    for (int k = 1; k < 10; k++) begin
      eval_cyc("mdu_busy"); cnt += int'(exe_mem_flush); tick();
    end
    mdu_done = 1;
    eval_cyc("mdu_done");
    check_val("mdu_done_nostall", pc_stall, 1'b0);
    tick();
    mdu_done = 0;
    check_val("mdu_stall_cycles", cnt, 10);
    eval_cyc("mdu_after"); tick();

    // MDU op that never completes: watchdog release.
    exe_mdu_start = 1;
    eval_cyc("wd_start"); tick();
    exe_mdu_start = 0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      eval_cyc("wd_busy");
      if (!pc_stall) break;
      cnt++;
      tick();
    end
    check_val("wd_release_cycles", cnt, MDU_TIMEOUT);
    check_val("wd_timeout_set", mdu_timeout, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin eval_cyc("wd_sticky"); tick(); end
    check_val("wd_timeout_sticky", mdu_timeout, 1'b1);

    // Freeze beats a concurrent load-use and redirect for three cycles.
    idle();
    mem_req_valid = 1; mem_ready = 0; id_redirect = 1;
    exe_is_load = 1; exe_rd = 9; exe_reg_wen = 1; id_rs2 = 9; id_use_rs2 = 1;
    for (int i = 0; i < 3; i++) begin
      eval_cyc("freeze");
      check_val("freeze_ctrl", {if_id_flush, id_exe_flush, exe_mem_stall, mem_wb_flush}, 4'b0011);
      tick();
    end
    mem_ready = 1;
    eval_cyc("freeze_end");
    check_val("freeze_end_lu", {if_id_flush, id_exe_flush}, 2'b01);
    tick();

    // Reset in the middle of an MDU op.
    idle();
    exe_mdu_start = 1; eval_cyc("rstmdu_start"); tick();
    exe_mdu_start = 0;
    for (int i = 0; i < 3; i++) begin eval_cyc("rstmdu_busy"); tick(); end
    rst = 1;
    eval_cyc("rstmdu_rst0");
    check_val("rstmdu_stalls", {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall}, 4'b0000);
    tick();
    eval_cyc("rstmdu_rst1");
    check_val("rstmdu_timeout", mdu_timeout, 1'b0);
    tick();
    rst = 0;
    eval_cyc("rstmdu_run");
    check_val("rstmdu_run_stall", pc_stall, 1'b0);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_use_rs1    = 1'($urandom);
      id_use_rs2    = 1'($urandom);
      id_is_branch  = 1'($urandom);
      id_redirect   = ($urandom_range(0, 3) == 0);
      exe_rd        = 5'($urandom_range(0, 3));
      exe_reg_wen   = 1'($urandom);
      exe_is_load   = 1'($urandom);
      exe_mdu_start = ($urandom_range(0, 11) == 0);
      mdu_done      = (i > 2000) ? 1'b0 : ($urandom_range(0, 7) == 0);
      mem_rd        = 5'($urandom_range(0, 3));
      mem_reg_wen   = 1'($urandom);
      mem_is_load   = 1'($urandom);
      mem_req_valid = ($urandom_range(0, 9) < 3);
      mem_ready     = ($urandom_range(0, 9) < 6);
      eval_cyc("random");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
